design_alu_edge: RTL and testbench
==================================

# design_alu_edge

Single-bit edge detector: samples a level input on every clock and emits one-cycle pulses on its rising and falling transitions. It sits at the boundary between slow control/status levels and event-driven logic, such as interrupt sources, counters and FSM triggers. It provides an optional input synchronizer and is parameterized to a vector of independent lanes. All outputs come directly from flops or flop-to-flop logic and are glitch-free.

## Interface
Parameters:
- WIDTH, 1: number of independent lanes; each bit of d_in has its own detector.
- SYNC_STAGES, 0: extra flop stages ahead of detection. Use 0 for inputs already synchronous to clk, and 2 or more for asynchronous sources.
- RESET_VAL, 1'b0: value loaded into every history/sync flop on reset, per lane. It defines the "previous level" for the first post-reset sample.

Ports:
- clk, input, 1: single clock; all state updates on the posedge.
- reset, input, 1: asynchronous, active-low reset. reset=0 clears state immediately, independent of clk; state releases on deassertion.
- d_in, input, WIDTH: level input to monitor.
- rising_edge, output, WIDTH: per-lane one-cycle pulse on a 0→1 transition.
- falling_edge, output, WIDTH: per-lane one-cycle pulse on a 1→0 transition.

## Operation
- Sync chain, when SYNC_STAGES>0: d_in shifts through SYNC_STAGES flops. Its output, s, is the value fed to detection. With SYNC_STAGES=0, s = d_in.
- Detection flops:
  - cur <= s each posedge.
  - prev <= cur each posedge.
- Outputs:
  - rising_edge = cur & ~prev
  - falling_edge = ~cur & prev
  - Both are per bit, from flops only.
- rising_edge and falling_edge are never high together on the same lane.
- A constant input produces no pulses.
- A toggling input (0,1,0,1 on successive samples) produces rising and falling pulses on alternate cycles.
- Each lane is fully independent; lanes share no state.

## Timing
- Reset (reset=0):
  - All sync, cur and prev flops are set to RESET_VAL.
  - Both outputs are 0 within the reset assertion, asynchronously.
- First sample after reset release: compared against RESET_VAL.
  - With the default RESET_VAL=0, a d_in already at 1 produces one rising_edge pulse.
  - With RESET_VAL=1 per lane, that lane produces a falling_edge pulse instead.
- Latency with SYNC_STAGES=0:
  - If d_in changes before posedge k, cur takes the new value at posedge k.
  - The pulse is high from just after posedge k until just after posedge k+1: exactly one clock period.
- Latency with SYNC_STAGES=N: the pulse starts N cycles later. The pulse width is still exactly one cycle.
- Pulse granularity:
  - A level held for 1 sample produces one rise pulse followed by one fall pulse on the next cycle.
  - Glitches shorter than a clock period that are not sampled produce no pulse.
- Reset asserted mid-pulse: the pulse is truncated immediately and no pulse is generated on release unless the first sample differs from RESET_VAL.
- There is no handshake. Pulses are not held or queued, and the consumer must sample on every clk.

## Structure
- No shared package is required.
  - WIDTH and RESET_VAL use the codebase's standard logic types.
  - If a common pkg already defines lane-width constants, WIDTH defaults from it.
- One natural sub-module: design_alu_sync. It is a parameterized N-stage, WIDTH-wide synchronizer with async active-low reset, instantiated only when SYNC_STAGES>0 (generate).
- Top level contains the cur/prev registers and the combinational pulse logic.

## Test plan
All scenarios use WIDTH=1, SYNC_STAGES=0 and RESET_VAL=0 unless stated.
- Reset: hold reset=0 with d_in=1 → rising_edge=0 and falling_edge=0. Assert reset asynchronously mid-cycle → outputs drop to 0 without waiting for a clk edge.
- Rising edge: release reset with d_in=0 for 2 cycles, then d_in=1 → rising_edge=1 for exactly one cycle after the sampling edge; falling_edge stays 0.
- Falling edge: d_in 1→0 after a stable 1 → falling_edge=1 for one cycle; rising_edge stays 0.
- Toggle: d_in toggles every cycle for 8 cycles → alternating single-cycle rise/fall pulses with no overlap.
- Random stream: 32 random d_in bits → each cycle rising_edge == cur & ~prev per a scoreboard model, and never both outputs high. Also check the first-sample-after-reset rule with d_in=1 at release → one rising pulse.
- Parameter variants:
  - SYNC_STAGES=2 → pulses delayed exactly 2 cycles versus the baseline.
  - WIDTH=4 with independent lane stimulus → per-lane pulses with no crosstalk.
  - RESET_VAL=1 with d_in=0 at release → one falling pulse.

Source files
------------

// File: rtl/design_alu_edge_pkg.sv
// Shared types for the edge detector: per-lane pulse pair and the pulse rule.
package design_alu_edge_pkg;

    localparam int LANE_W = 1;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    function automatic edge_t detect(input logic cur, input logic prev);
        edge_t e;
        e.rise = cur & ~prev;
        e.fall = ~cur & prev;
        return e;
    endfunction

endpackage

// File: rtl/design_alu_sync.sv
// N-stage, WIDTH-wide synchronizer; every stage resets to the lane's RESET_VAL.
module design_alu_sync
    import design_alu_edge_pkg::*;
#(
    parameter int unsigned       WIDTH     = LANE_W,
    parameter int unsigned       STAGES    = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d_in;
            for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
        end
    end

    assign d_out = stage[STAGES-1];

endmodule

// File: rtl/design_alu_edge.sv
// Per-lane rising/falling edge detector with optional input synchronizer.
module design_alu_edge
    import design_alu_edge_pkg::*;
#(
    parameter int unsigned       WIDTH       = LANE_W,
    parameter int unsigned       SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] rising_edge,
    output logic [WIDTH-1:0] falling_edge
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            design_alu_sync #(
                .WIDTH    (WIDTH),
                .STAGES   (SYNC_STAGES),
                .RESET_VAL(RESET_VAL)
            ) u_sync (
                .clk  (clk),
                .reset(reset),
                .d_in (d_in),
                .d_out(s)
            );
        end else begin : g_nosync
            assign s = d_in;
        end
    endgenerate

    // cur == prev == RESET_VAL during reset, so both pulses are forced low asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur  <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            cur  <= s;
            prev <= cur;
        end
    end

    generate
        for (genvar l = 0; l < int'(WIDTH); l++) begin : g_lane
            edge_t e;
            assign e               = detect(cur[l], prev[l]);
            assign rising_edge[l]  = e.rise;
            assign falling_edge[l] = e.fall;
        end
    endgenerate

endmodule

// File: tb/tb_design_alu_edge.sv
// Bench for design_alu_edge: baseline, 2-stage sync, 4-lane and RESET_VAL=1 variants.
module tb_design_alu_edge;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       d_b = 1'b0;
    logic [3:0] d_w = 4'h0;
    logic       d_r = 1'b0;

    logic       rb, fb, rs, fs, rr, fr;
    logic [3:0] rw, fw;

    int errors = 0;
    int checks = 0;

    // Sample history per input, newest first; reset refills it with RESET_VAL.
    logic       qb[$];
    logic [3:0] qw[$];
    logic       qr[$];

    always #5 clk = ~clk;

    design_alu_edge #(.WIDTH(1), .SYNC_STAGES(0), .RESET_VAL(1'b0)) u_base (
        .clk(clk), .reset(reset), .d_in(d_b), .rising_edge(rb), .falling_edge(fb));
    design_alu_edge #(.WIDTH(1), .SYNC_STAGES(2), .RESET_VAL(1'b0)) u_sync (
        .clk(clk), .reset(reset), .d_in(d_b), .rising_edge(rs), .falling_edge(fs));
    design_alu_edge #(.WIDTH(4), .SYNC_STAGES(0), .RESET_VAL(4'h0)) u_wide (
        .clk(clk), .reset(reset), .d_in(d_w), .rising_edge(rw), .falling_edge(fw));
    design_alu_edge #(.WIDTH(1), .SYNC_STAGES(0), .RESET_VAL(1'b1)) u_rv1 (
        .clk(clk), .reset(reset), .d_in(d_r), .rising_edge(rr), .falling_edge(fr));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_model();
        qb = {1'b0, 1'b0, 1'b0, 1'b0};
        qw = {4'h0, 4'h0};
        qr = {1'b1, 1'b1};
    endtask

    // Outputs must equal "newest sample seen by detector is 1 and the one before is 0" (and vice versa).
    task automatic check_all(input string tag);
        chk({tag, "_base_r"}, {3'b0, rb}, {3'b0, qb[0] & !qb[1]});
        chk({tag, "_base_f"}, {3'b0, fb}, {3'b0, !qb[0] & qb[1]});
        chk({tag, "_sync_r"}, {3'b0, rs}, {3'b0, qb[2] & !qb[3]});
        chk({tag, "_sync_f"}, {3'b0, fs}, {3'b0, !qb[2] & qb[3]});
        chk({tag, "_wide_r"}, rw, qw[0] & ~qw[1]);
        chk({tag, "_wide_f"}, fw, ~qw[0] & qw[1]);
        chk({tag, "_rv1_r"},  {3'b0, rr}, {3'b0, qr[0] & !qr[1]});
        chk({tag, "_rv1_f"},  {3'b0, fr}, {3'b0, !qr[0] & qr[1]});
        chk({tag, "_excl"},   {rb & fb, rs & fs, rr & fr, 1'b0} | (rw & fw), 4'h0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) begin
            fill_model();
        end else begin
            qb.push_front(d_b); qb.pop_back();
            qw.push_front(d_w); qw.pop_back();
            qr.push_front(d_r); qr.pop_back();
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        fill_model();
        // Reset held with inputs opposite the reset value: no pulses.
        d_b = 1'b1; d_w = 4'hF; d_r = 1'b0;
        #2;
        check_all("rst_async");
        for (int i = 0; i < 2; i++) step("rst_hold");
        reset = 1'b1;
        // First samples after release compare against RESET_VAL.
        for (int i = 0; i < 4; i++) step("first");

        // Rising then falling after stable levels.
        d_b = 1'b0; d_w = 4'h0; d_r = 1'b1;
        for (int i = 0; i < 4; i++) step("low");
        d_b = 1'b1; d_w = 4'b0101; d_r = 1'b0;
        for (int i = 0; i < 4; i++) step("rise");
        d_b = 1'b0; d_w = 4'b1010; d_r = 1'b1;
        for (int i = 0; i < 4; i++) step("fall");

        // Toggle every cycle.
        for (int i = 0; i < 8; i++) begin
            d_b = ~d_b; d_w = ~d_w; d_r = ~d_r;
            step("toggle");
        end

        // Random stream, independent per lane.
        for (int i = 0; i < 32; i++) begin
            d_b = 1'($urandom_range(1));
            d_w = 4'($urandom_range(15));
            d_r = 1'($urandom_range(1));
            step("rand");
        end

        // Mid-pulse async reset truncates the pulse before the next edge.
        d_b = 1'b0; d_w = 4'h0; d_r = 1'b1;
        for (int i = 0; i < 4; i++) step("pre_mid");
        d_b = 1'b1; d_w = 4'h9; d_r = 1'b0;
        step("mid_pulse");
        #2;
        reset = 1'b0;
        fill_model();
        #1;
        check_all("mid_rst");
        step("mid_hold");
        d_b = 1'b0; d_w = 4'h0; d_r = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
